// File: rtl/reg_bank_write.sv
// Write side of an N x Bits register bank: buffered valid/ready writes plus a drain-then-clear sequence.
// Define REG_BANK_ZERO_REG_EN to hardwire register 0 to zero (commits to index 0 are dropped).
module reg_bank_write #(
  parameter int N      = 32,
  parameter int Bits   = 64,
  parameter int DEPTH  = 2,
  localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [CW-1:0]   write_code,
  input  logic [Bits-1:0] wr_data,
  input  logic            clr_req,
  output logic            clr_done,
  output logic            busy,
  output logic [Bits-1:0] D [N-1:0]
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t            state_q;
  logic [CNTW-1:0]   count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     fifo_code_q [DEPTH-1:0];
  logic [Bits-1:0]   fifo_data_q [DEPTH-1:0];
  logic [Bits-1:0]   regs_q [N-1:0];
  logic [CW-1:0]     clr_idx_q;
  logic              clr_done_q;
  logic              push, pop, commit_ok;
  logic [CW-1:0]     head_code;
  logic [Bits-1:0]   head_data;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // wr_ready ignores a same-cycle pop, so a full FIFO never bypasses.
  always_comb begin
    wr_ready  = (state_q == IDLE) && (count_q < CNTW'(DEPTH));
    push      = wr_valid && wr_ready;
    pop       = (count_q != '0) && (state_q != CLEAR);
    head_code = fifo_code_q[rd_ptr_q];
    head_data = fifo_data_q[rd_ptr_q];
    commit_ok = pop && ({1'b0, head_code} < (CW + 1)'(N));
`ifdef REG_BANK_ZERO_REG_EN
    if (head_code == '0) commit_ok = 1'b0;
`else
    commit_ok = commit_ok && 1'b1;
`endif
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    busy = (state_q != IDLE) || (count_q != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      clr_idx_q  <= '0;
      clr_done_q <= 1'b0;
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
    end else begin
      clr_done_q <= 1'b0;
      count_q    <= count_d;
      if (push) begin
        fifo_code_q[wr_ptr_q] <= write_code;
        fifo_data_q[wr_ptr_q] <= wr_data;
        wr_ptr_q              <= nextPtr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= nextPtr(rd_ptr_q);
        if (commit_ok) regs_q[head_code] <= head_data;
      end
      // A clear requested alongside a write drains that write first.
      case (state_q)
        IDLE: begin
          if (clr_req) state_q <= (count_d != '0) ? DRAIN : CLEAR;
        end
        DRAIN: begin
          if (count_d == '0) state_q <= CLEAR;
        end
        CLEAR: begin
          regs_q[clr_idx_q] <= '0;
          if (clr_idx_q == CW'(N - 1)) begin
            clr_idx_q  <= '0;
            clr_done_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            clr_idx_q <= clr_idx_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign clr_done = clr_done_q;
  assign D        = regs_q;

endmodule

// File: tb/tb_reg_bank_write.sv
// Self-checking bench for reg_bank_write: directed scenarios plus a randomized write phase
// checked against a queue-based reference model of the bank.
module tb_reg_bank_write;

  localparam int N     = 32;
  localparam int N24   = 24;
  localparam int Bits  = 64;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            wrValid = 1'b0;
  logic            wrReady;
  logic [4:0]      writeCode = '0;
  logic [Bits-1:0] wrData = '0;
  logic            clrReq = 1'b0;
  logic            clrDone;
  logic            busy;
  logic [Bits-1:0] dOut [N-1:0];

  logic            wrValid24 = 1'b0;
  logic            wrReady24;
  logic [4:0]      writeCode24 = '0;
  logic [Bits-1:0] wrData24 = '0;
  logic            clrDone24;
  logic            busy24;
  logic [Bits-1:0] dOut24 [N24-1:0];

  int errors = 0;
  int checks = 0;

  typedef struct { int code; logic [Bits-1:0] data; } entry_t;
  logic [Bits-1:0] mregs [N];
  entry_t          mq [$];

  reg_bank_write #(.N(N), .Bits(Bits), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_valid(wrValid), .wr_ready(wrReady),
    .write_code(writeCode), .wr_data(wrData), .clr_req(clrReq),
    .clr_done(clrDone), .busy(busy), .D(dOut)
  );

  reg_bank_write #(.N(N24), .Bits(Bits), .DEPTH(DEPTH)) dut24 (
    .clk(clk), .reset(reset), .wr_valid(wrValid24), .wr_ready(wrReady24),
    .write_code(writeCode24), .wr_data(wrData24), .clr_req(1'b0),
    .clr_done(clrDone24), .busy(busy24), .D(dOut24)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input int code, input logic [Bits-1:0] data,
                               input logic clr);
    wrValid   = v;
    writeCode = 5'(code);
    wrData    = data;
    clrReq    = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [Bits-1:0] observed,
                             input logic [Bits-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelCommit(input int code, input logic [Bits-1:0] data);
    bit zeroReg = 1'b0;
`ifdef REG_BANK_ZERO_REG_EN
    zeroReg = 1'b1;
`endif
    if (code < N && !(zeroReg && code == 0)) mregs[code] = data;
  endtask

  task automatic checkBank(input string tag);
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("%s_D%0d", tag, i), dOut[i], mregs[i]);
  endtask

  task automatic modelZero();
    for (int i = 0; i < N; i++) mregs[i] = '0;
    mq.delete();
  endtask

  initial begin
    int edges;
    bit seenReadyHigh;
    bit seenDone;
    logic v;
    int code;
    logic [Bits-1:0] data;
    entry_t e;

    modelZero();
    $display("[TB] reset");
    tick();
    tick();
    reset = 1'b0;
    checkOutput("resetReady", wrReady, 1);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", clrDone, 0);
    checkBank("reset");

    $display("[TB] single write");
    applyStimulus(1, 6, 32, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("singleBusyPending", busy, 1);
    checkOutput("singleNotYet", dOut[6], 0);
    tick();
    modelCommit(6, 32);
    checkOutput("singleBusyDone", busy, 0);
    checkBank("single");

    $display("[TB] back-to-back writes");
    for (int i = 0; i < 4; i++) begin
      code = (i == 3) ? 1 : i + 1;
      data = Bits'((i + 1) * 10);
      applyStimulus(1, code, data, 0);
      checkOutput($sformatf("b2bReady%0d", i), wrReady, 1);
      tick();
      modelCommit(code, data);
    end
    applyStimulus(0, 0, 0, 0);
    tick();
    checkOutput("b2bD1", dOut[1], 40);
    checkOutput("b2bD2", dOut[2], 20);
    checkOutput("b2bD3", dOut[3], 30);
    checkBank("b2b");

    $display("[TB] clear with pending write");
    applyStimulus(1, 5, 7, 1);
    checkOutput("clrReadyBefore", wrReady, 1);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("drainReady", wrReady, 0);
    checkOutput("drainBusy", busy, 1);
    tick();
    checkOutput("drainCommitD5", dOut[5], 7);
    edges = 1;
    seenReadyHigh = 1'b0;
    while (clrDone !== 1'b1 && edges < 200) begin
      if (wrReady !== 1'b0) seenReadyHigh = 1'b1;
      tick();
      edges++;
    end
    checkOutput("clrLatency", 64'(edges), 64'(1 + N));
    checkOutput("clrReadyLow", 64'(seenReadyHigh), 0);
    checkOutput("clrDonePulse", clrDone, 1);
    modelZero();
    checkBank("cleared");
    tick();
    checkOutput("clrDoneOneCycle", clrDone, 0);
    checkOutput("clrReadyAfter", wrReady, 1);
    checkOutput("clrBusyAfter", busy, 0);

    $display("[TB] reset mid-clear");
    applyStimulus(1, 20, 64'habc, 0);
    tick();
    applyStimulus(0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("midClearD20", dOut[20], 64'habc);
    checkOutput("midClearBusy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    modelZero();
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortReady", wrReady, 1);
    checkOutput("abortDone", clrDone, 0);
    checkBank("abort");
    seenDone = 1'b0;
    for (int i = 0; i < N + 5; i++) begin
      if (clrDone !== 1'b0) seenDone = 1'b1;
      tick();
    end
    checkOutput("abortNoDone", 64'(seenDone), 0);

    $display("[TB] out-of-range code, N=24");
    wrValid24 = 1'b1; writeCode24 = 5'd30; wrData24 = 64'd99;
    tick();
    checkOutput("oorReady1", wrReady24, 1);
    writeCode24 = 5'd23; wrData24 = 64'd5;
    tick();
    checkOutput("oorReady2", wrReady24, 1);
    wrValid24 = 1'b0;
    tick();
    for (int i = 0; i < N24; i++)
      checkOutput($sformatf("oorD%0d", i), dOut24[i], (i == 23) ? 64'd5 : 64'd0);
    checkOutput("oorBusy", busy24, 0);

    $display("[TB] register 0 writes");
    applyStimulus(1, 0, 55, 0);
    tick();
    modelCommit(0, 55);
    applyStimulus(1, 2, 6, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    tick();
    modelCommit(2, 6);
`ifdef REG_BANK_ZERO_REG_EN
    checkOutput("zeroRegD0", dOut[0], 0);
`else
    checkOutput("plainRegD0", dOut[0], 55);
`endif
    checkOutput("zeroRegD2", dOut[2], 6);
    checkBank("zeroReg");

    $display("[TB] random writes");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    modelZero();
    for (int cyc = 0; cyc < 300; cyc++) begin
      v    = 1'($urandom_range(0, 3) != 0);
      code = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 3) == 0) code = int'($urandom_range(0, 3));
      data = {$urandom, $urandom};
      applyStimulus(v, code, data, 0);
      checkOutput($sformatf("rndReady%0d", cyc), wrReady, 64'(mq.size() < DEPTH));
      if (mq.size() > 0) begin
        e = mq.pop_front();
        modelCommit(e.code, e.data);
        if (v) mq.push_back('{code, data});
      end else if (v) begin
        mq.push_back('{code, data});
      end
      tick();
      checkOutput($sformatf("rndBusy%0d", cyc), busy, 64'(mq.size() != 0));
      checkBank($sformatf("rnd%0d", cyc));
    end
    applyStimulus(0, 0, 0, 0);
    while (mq.size() > 0) begin
      e = mq.pop_front();
      modelCommit(e.code, e.data);
      tick();
    end
    checkOutput("rndFinalBusy", busy, 0);
    checkBank("rndFinal");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
